// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM access arbiter.
// Includes the FSM state encoding, the requester indices and the default widths.
package rom_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_e;

  // Expands a requester index into a {B, A} one-hot strobe pair.
  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] oh;
    if (idx == REQ_B) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rom_arb_chk.sv
// Protocol checker for rom_access_arbiter: strobe exclusivity and ROM bus
// ownership (the ROM may only drive the bus in the cycle after a grant).
module rom_arb_chk (
  input logic clk_i,
  input logic rst_n_i,
  input logic gnt_a_i,
  input logic gnt_b_i,
  input logic valid_a_i,
  input logic valid_b_i,
  input logic rom_en_i,
  input logic busy_i
);

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(gnt_a_i && gnt_b_i))
    else $error("grant strobes overlap");

  a_valid_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(valid_a_i && valid_b_i))
    else $error("valid strobes overlap");

  a_en_after_gnt: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    rom_en_i |-> $past(gnt_a_i || gnt_b_i))
    else $error("ROM enabled without a preceding grant");

  a_valid_after_en: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (valid_a_i || valid_b_i) |-> $past(rom_en_i))
    else $error("valid without a preceding ROM enable");

  a_en_busy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    rom_en_i |-> busy_i)
    else $error("ROM enabled while idle");

endmodule

// File: rtl/rom_arb_rr_pick.sv
// Two-way winner selection: round-robin with a last-grant pointer, or fixed
// priority to requester A when FIXED_PRIO is non-zero.
module rom_arb_rr_pick
  import rom_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic take_i,
  output logic any_o,
  output logic winner_o
);

  logic last_q;
  logic last_d;

  // Winner selection; a tie goes to whichever requester was not granted last.
  always_comb begin
    any_o    = req_a_i | req_b_i;
    winner_o = REQ_A;
    if (FIXED_PRIO != 0) begin
      if (req_a_i) begin
        winner_o = REQ_A;
      end else begin
        winner_o = REQ_B;
      end
    end else if (req_a_i && req_b_i) begin
      if (last_q == REQ_A) begin
        winner_o = REQ_B;
      end else begin
        winner_o = REQ_A;
      end
    end else if (req_b_i) begin
      winner_o = REQ_B;
    end else begin
      winner_o = REQ_A;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    if (take_i && any_o) begin
      last_d = winner_o;
    end else begin
      last_d = last_q;
    end
  end

  // Resetting the pointer to B makes A win the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Arbitrates a single synchronous ROM between a CPU fetch port (A) and a
// loader/debug port (B); one read per two cycles when back-to-back.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReqA,
  input  logic              iReqB,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [ADDR_W-1:0] iAddrB,
  output logic              oGntA,
  output logic              oGntB,
  output logic              oValidA,
  output logic              oValidB,
  output logic [DATA_W-1:0] oDataA,
  output logic [DATA_W-1:0] oDataB,
  output logic [ADDR_W-1:0] oRomAddr,
  output logic              oRomEnable,
  input  logic [DATA_W-1:0] iRomData,
  output logic              oBusy
);

  arb_state_e        state_q;
  logic              win_q;
  logic              gnt_a_q;
  logic              gnt_b_q;
  logic              valid_a_q;
  logic              valid_b_q;
  logic [DATA_W-1:0] data_a_q;
  logic [DATA_W-1:0] data_b_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              rom_en_q;
  logic              busy_q;

  logic              arb_en_s;
  logic              any_s;
  logic              winner_s;
  logic [1:0]        win_oh_s;
  logic [ADDR_W-1:0] win_addr_s;

  // Requests are only looked at on the IDLE and CAPTURE edges.
  always_comb begin
    arb_en_s = (state_q == IDLE) || (state_q == CAPTURE);
    win_oh_s = req_onehot(winner_s);
    if (winner_s == REQ_B) begin
      win_addr_s = iAddrB;
    end else begin
      win_addr_s = iAddrA;
    end
  end

  rom_arb_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .clk_i    (iClk),
    .rst_n_i  (iRst),
    .req_a_i  (iReqA),
    .req_b_i  (iReqB),
    .take_i   (arb_en_s),
    .any_o    (any_s),
    .winner_o (winner_s)
  );

  // Read sequencer and registered outputs; strobes default low each cycle.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q    <= IDLE;
      win_q      <= REQ_A;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      data_a_q   <= {DATA_W{1'b0}};
      data_b_q   <= {DATA_W{1'b0}};
      rom_addr_q <= {ADDR_W{1'b0}};
      rom_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      case (state_q)
        ISSUE: begin
          state_q  <= CAPTURE;
          rom_en_q <= 1'b1;
          busy_q   <= 1'b1;
        end
        IDLE, CAPTURE: begin
          rom_en_q <= 1'b0;
          if (state_q == CAPTURE) begin
            if (win_q == REQ_B) begin
              data_b_q  <= iRomData;
              valid_b_q <= 1'b1;
            end else begin
              data_a_q  <= iRomData;
              valid_a_q <= 1'b1;
            end
          end
          if (any_s) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            win_q      <= winner_s;
            rom_addr_q <= win_addr_s;
            gnt_a_q    <= win_oh_s[0];
            gnt_b_q    <= win_oh_s[1];
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rom_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign oGntA      = gnt_a_q;
  assign oGntB      = gnt_b_q;
  assign oValidA    = valid_a_q;
  assign oValidB    = valid_b_q;
  assign oDataA     = data_a_q;
  assign oDataB     = data_b_q;
  assign oRomAddr   = rom_addr_q;
  assign oRomEnable = rom_en_q;
  assign oBusy      = busy_q;

endmodule

// File: doc/rom_access_arbiter.md
ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: ROM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: ROM word width.
REQ-003 SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 makes requester A always win.
REQ-004 SHALL have port iClk, input, 1: sole clock; all logic on the rising edge.
REQ-005 SHALL have port iRst, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have ports iReqA / iReqB, input, 1: read request from requester A (CPU fetch) or B (loader/debug).
REQ-007 SHALL have ports iAddrA / iAddrB, input, ADDR_W: read address, held stable while the matching iReq is high.
REQ-008 SHALL have ports oGntA / oGntB, output, 1: one-cycle pulse meaning the request was accepted.
REQ-009 SHALL have ports oValidA / oValidB, output, 1: one-cycle pulse meaning oDataA / oDataB holds read data.
REQ-010 SHALL have ports oDataA / oDataB, output, DATA_W: registered read data, held until the next capture for that requester.
REQ-011 SHALL have port oRomAddr, output, ADDR_W: registered address driven to the ROM.
REQ-012 SHALL have port oRomEnable, output, 1: ROM output-enable, which drives the shared data bus.
REQ-013 SHALL have port iRomData, input, DATA_W: ROM data; valid only while oRomEnable is high, one cycle after the address.
REQ-014 SHALL have port oBusy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE and CAPTURE, with all outputs registered.
REQ-016 In IDLE at edge E0 with any request, the FSM SHALL select a winner, load oRomAddr with the winner's address, pulse the winner's oGnt for the following cycle and enter ISSUE.
REQ-017 ISSUE SHALL last one cycle and SHALL not sample requests; at E1 it enters CAPTURE with oRomEnable=1.
REQ-018 At E2 in CAPTURE, iRomData SHALL be captured into the winner's oData, that requester's oValid SHALL be pulsed for one cycle, and oRomEnable SHALL be cleared.
REQ-019 At E2 in CAPTURE, requests SHALL be arbitrated exactly as in IDLE, entering ISSUE if any request is pending and IDLE otherwise, giving back-to-back throughput of one read per 2 cycles.
REQ-020 Grant-to-valid latency SHALL be 2 cycles (oGnt in cycle N, oValid in cycle N+2); request-to-valid latency SHALL be 3 edges from idle.
REQ-021 Handshake: a requester still holding iReq high at an arbitration edge (E0 or E2) after its oGnt SHALL be treated as issuing a new request.
REQ-022 Round-robin: on a simultaneous request, the requester not granted last SHALL win; the last-grant pointer SHALL update only on a grant; after reset A SHALL win the first tie.
REQ-023 With FIXED_PRIO=1, A SHALL win every tie and B SHALL be served only when iReqA is low at the arbitration edge.
REQ-024 oRomEnable SHALL be high only in CAPTURE, so the ROM never drives the bus outside a read.
REQ-025 At most one oGnt and at most one oValid SHALL be high in any cycle; oValid for a read and oGnt for the next read MAY be high in the same cycle.
REQ-026 Address width SHALL wrap naturally, with no range check: address 2^ADDR_W-1 SHALL be legal.

Reset
REQ-027 While iRst=0 at an edge, the block SHALL enter IDLE and clear oGntA/B, oValidA/B, oRomEnable, oBusy, oRomAddr and oDataA/B to 0, and reset the RR pointer to favour A.
REQ-028 A reset in ISSUE or CAPTURE SHALL abort the read with no oValid pulse; a request held through reset SHALL be arbitrated at the first edge with iRst=1.

Structure
REQ-029 Package rom_arb_pkg SHALL hold the state enum (IDLE, ISSUE, CAPTURE), the requester index constants (REQ_A=0, REQ_B=1) and the default ADDR_W / DATA_W.
REQ-030 The two-way winner selection (round-robin or fixed priority plus pointer) SHALL be one sub-module, rom_arb_rr_pick; the FSM and datapath SHALL stay in the top level.

Verification
REQ-031 A alone requests 0x00 with the ROM model returning 0x24000200 -> oGntA in cycle 1, oRomEnable in cycle 2, oValidA in cycle 3 with oDataA=0x24000200, then oBusy=0.
REQ-032 A (0x01) and B (0x02) requested together and held -> grants alternate A,B,A,B every 2 cycles; oDataB=0x64700000 on B's first valid.
REQ-033 FIXED_PRIO=1 with A continuously requesting and B also requesting -> B is never granted until iReqA drops, then oGntB follows at the next arbitration edge.
REQ-034 Reset asserted in CAPTURE of a read to 0x1C -> no oValid, all outputs 0 next cycle; a request held through reset is granted at the first edge after release.
REQ-035 Read of 0xFF, then 0x00 back-to-back from B -> correct data for both reads, oRomEnable never high in IDLE or ISSUE, bus-contention checker silent.
